// File: rtl/map_collision_pkg.sv
// Shared constants, FSM encoding and direction helper for the map collision responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package map_collision_pkg;

  // Bit positions inside the free-direction vector
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int CHIP_SHIFT_DEF = 5;
  localparam int NUM_PROBES     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Probe pairs: 0,1 up | 2,3 down | 4,5 left | 6,7 right.
  // A direction is free only when both of its edge probes are passable.
  function automatic logic [3:0] dir_free(input logic [NUM_PROBES-1:0] solid);
    logic [3:0] d;
    d            = '0;
    d[DIR_UP]    = ~(solid[0] | solid[1]);
    d[DIR_DOWN]  = ~(solid[2] | solid[3]);
    d[DIR_LEFT]  = ~(solid[4] | solid[5]);
    d[DIR_RIGHT] = ~(solid[6] | solid[7]);
    return d;
  endfunction

endpackage

// File: rtl/map_collision_probe_addr.sv
// Probe k -> {out-of-map flag, tile address} for the snapshotted user box.
// Latency: purely combinational.
// Backpressure: none; the caller muxes the probe index one per cycle.
//  probe_idx       : probe 0..7 (see dir_free for pairing)
//  uxs/uys/uxe/uye : user box, screen px (uxe/uye exclusive)
//  fxs/fys         : field scroll, px
//  map_w/map_h     : map size in chips
//  oob             : probe lies outside the map (treated as solid)
//  addr            : fy_chip*map_w + fx_chip, forced to 0 when oob
module map_collision_probe_addr #(
  parameter int CHIP_SHIFT = 5
) (
  input  logic [2:0]  probe_idx,
  input  logic [9:0]  uxs,
  input  logic [9:0]  uys,
  input  logic [9:0]  uxe,
  input  logic [9:0]  uye,
  input  logic [15:0] fxs,
  input  logic [15:0] fys,
  input  logic [15:0] map_w,
  input  logic [15:0] map_h,
  output logic        oob,
  output logic [15:0] addr
);

  function automatic logic signed [16:0] ext(input logic [9:0] v);
    return signed'({7'b0, v});
  endfunction

  logic signed [16:0] sx, sy;
  logic signed [16:0] fx, fy;
  logic [15:0]        cx, cy;

  always_comb begin
    sx = ext(uxs);
    sy = ext(uys);
    unique case (probe_idx)
      3'd0: begin sx = ext(uxs);         sy = ext(uys) - 17'sd1; end
      3'd1: begin sx = ext(uxe) - 17'sd1; sy = ext(uys) - 17'sd1; end
      3'd2: begin sx = ext(uxs);         sy = ext(uye);          end
      3'd3: begin sx = ext(uxe) - 17'sd1; sy = ext(uye);          end
      3'd4: begin sx = ext(uxs) - 17'sd1; sy = ext(uys);          end
      3'd5: begin sx = ext(uxs) - 17'sd1; sy = ext(uye) - 17'sd1; end
      3'd6: begin sx = ext(uxe);         sy = ext(uys);          end
      default: begin sx = ext(uxe);      sy = ext(uye) - 17'sd1; end
    endcase

    fx = sx + signed'({1'b0, fxs});
    fy = sy + signed'({1'b0, fys});

    // Negative coords are caught by the sign bit, so the chip index only
    // needs the magnitude bits; for non-negative values >> equals >>>.
    cx = fx[15:0] >> CHIP_SHIFT;
    cy = fy[15:0] >> CHIP_SHIFT;

    oob = fx[16] | fy[16] | (cx >= map_w) | (cy >= map_h);

    // 16x16 product deliberately truncated; maps are limited to W*H<=65536.
    // Out-of-map probes still issue a read (at 0) so 8 responses always return.
    addr = oob ? 16'd0 : 16'(cy * map_w + cx);
  end

endmodule

// File: rtl/map_collision.sv
// Collision responder: per 1 ms tick reads the 8 map tiles just outside the user box, publishes free-direction vector.
// Latency: tick -> oDone >= 1 + 8 + RAM latency + 1 cycles; oErr after TIMEOUT cycles without 8 responses.
// Backpressure: none; RAM must accept one read per cycle, ticks while busy are dropped.
//  iCLK, iRST            : clock, async active-low reset
//  iEn1Ms                : scan start tick
//  iUXS..iUYE, iFXS/iFYS : user box (screen px) and field scroll (px)
//  iMapWidth/iMapHeight  : map size in chips
//  oMapRd/oMapAddr       : map RAM read strobe and address
//  iMapData/iMapValid    : in-order RAM response
//  oMapDirect            : free bits up[3] down[2] left[1] right[0]
//  oBusy/oDone/oErr      : scan status, update pulse, timeout pulse
module map_collision
  import map_collision_pkg::*;
#(
  parameter int CHIP_SHIFT = CHIP_SHIFT_DEF,
  parameter int DATA_W     = 8,
  parameter int SOLID_BASE = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEn1Ms,
  input  logic [9:0]        iUXS,
  input  logic [9:0]        iUYS,
  input  logic [9:0]        iUXE,
  input  logic [9:0]        iUYE,
  input  logic [15:0]       iFXS,
  input  logic [15:0]       iFYS,
  input  logic [15:0]       iMapWidth,
  input  logic [15:0]       iMapHeight,
  output logic              oMapRd,
  output logic [15:0]       oMapAddr,
  input  logic [DATA_W-1:0] iMapData,
  input  logic              iMapValid,
  output logic [3:0]        oMapDirect,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);

  localparam int                CW       = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] SOLID_TH = DATA_W'(SOLID_BASE);

  state_t        state;

  // Snapshot of the geometry taken at the tick; inputs may move mid-scan
  logic [9:0]    uxs_q, uys_q, uxe_q, uye_q;
  logic [15:0]   fxs_q, fys_q, mw_q, mh_q;

  logic [2:0]    iss_idx;
  logic [3:0]    rsp_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [7:0]    oob_q;
  logic [7:0]    solid_q;

  logic          probe_oob;
  logic [15:0]   probe_addr;

  map_collision_probe_addr #(
    .CHIP_SHIFT (CHIP_SHIFT)
  ) u_probe (
    .probe_idx (iss_idx),
    .uxs       (uxs_q),
    .uys       (uys_q),
    .uxe       (uxe_q),
    .uye       (uye_q),
    .fxs       (fxs_q),
    .fys       (fys_q),
    .map_w     (mw_q),
    .map_h     (mh_q),
    .oob       (probe_oob),
    .addr      (probe_addr)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state      <= ST_IDLE;
      uxs_q      <= '0;
      uys_q      <= '0;
      uxe_q      <= '0;
      uye_q      <= '0;
      fxs_q      <= '0;
      fys_q      <= '0;
      mw_q       <= '0;
      mh_q       <= '0;
      iss_idx    <= '0;
      rsp_cnt    <= '0;
      cyc_cnt    <= '0;
      oob_q      <= '0;
      solid_q    <= '0;
      oMapRd     <= 1'b0;
      oMapAddr   <= '0;
      oMapDirect <= 4'b0000;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      oMapRd <= 1'b0;
      oDone  <= 1'b0;
      oErr   <= 1'b0;

      // Responses can overlap the issue phase; oob_q[k] is written on the
      // same edge that raises read k, so it is always ready before data k.
      if ((state == ST_ISSUE || state == ST_WAIT) && iMapValid && (rsp_cnt < 4'd8)) begin
        solid_q[rsp_cnt[2:0]] <= (iMapData >= SOLID_TH) | oob_q[rsp_cnt[2:0]];
        rsp_cnt               <= rsp_cnt + 4'd1;
      end

      unique case (state)
        ST_IDLE: begin
          if (iEn1Ms) begin
            uxs_q   <= iUXS;
            uys_q   <= iUYS;
            uxe_q   <= iUXE;
            uye_q   <= iUYE;
            fxs_q   <= iFXS;
            fys_q   <= iFYS;
            mw_q    <= iMapWidth;
            mh_q    <= iMapHeight;
            iss_idx <= '0;
            rsp_cnt <= '0;
            cyc_cnt <= '0;
            oob_q   <= '0;
            solid_q <= '0;
            oBusy   <= 1'b1;
            state   <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          oMapRd         <= 1'b1;
          oMapAddr       <= probe_addr;
          oob_q[iss_idx] <= probe_oob;
          iss_idx        <= iss_idx + 3'd1;
          cyc_cnt        <= cyc_cnt + CW'(1);
          if (iss_idx == 3'd7) state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (rsp_cnt == 4'd8) begin
            state <= ST_UPDATE;
          end else if (cyc_cnt == CW'(TIMEOUT - 1)) begin
            // Abandon the scan; the previous direction vector stays valid
            oErr  <= 1'b1;
            oBusy <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end

        default: begin // ST_UPDATE
          oMapDirect <= dir_free(solid_q);
          oDone      <= 1'b1;
          oBusy      <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
